booth_mult_param: RTL

- Parametrised sequential radix-2 Booth multiplier; next generation of the datapath's fixed 32-bit signed multiplier.
- Adds configurable operand width, per-operation signed/unsigned mode (MULT and MULTU), an explicit busy flag and a defined start/stop handshake.
- Sits beside the ALU. The control unit pulses start, stalls until stop, then writes HI/LO.

---
 rtl/mult_pkg.sv | 14 +
 rtl/booth_mult_param_if.sv | 25 ++
 rtl/booth_radix2_step.sv | 27 ++
 rtl/booth_mult_param.sv | 91 +++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states and radix-2 recode pairs.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // P[1:0] patterns that trigger an add or subtract of the multiplicand.
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_mult_param_if.sv
// Start/stop handshake, operands and product halves between the control unit and the multiplier.
interface booth_mult_param_if #(
  parameter int WIDTH = 32
) ();

  logic             w_MultStart;
  logic             w_Signed;
  logic [WIDTH-1:0] w_A;
  logic [WIDTH-1:0] w_B;
  logic             w_MultBusy;
  logic             w_MultStop;
  logic [WIDTH-1:0] w_MULTHI;
  logic [WIDTH-1:0] w_MULTLO;

  modport master (
    output w_MultStart, w_Signed, w_A, w_B,
    input  w_MultBusy, w_MultStop, w_MULTHI, w_MULTLO
  );

  modport slave (
    input  w_MultStart, w_Signed, w_A, w_B,
    output w_MultBusy, w_MultStop, w_MULTHI, w_MULTLO
  );

endinterface

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth step: conditional add/sub of the multiplicand, then arithmetic shift right.
module booth_radix2_step
  import mult_pkg::*;
#(
  parameter int PW = 67
) (
  input  logic [PW-1:0] p,
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] s,
  output logic [PW-1:0] p_next
);

  logic [PW-1:0] sum;

  always_comb begin
    // NOTE: every always_comb output gets a default before the case, otherwise an unlisted path infers a latch.
    sum = p;
    case (p[1:0])
      BOOTH_ADD: sum = p + a;
      BOOTH_SUB: sum = p + s;
      default:   sum = p;
    endcase
    // Carry out of the add is dropped; the shift replicates the sign bit.
    p_next = {sum[PW-1], sum[PW-1:1]};
  end

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed (MULT) or unsigned (MULTU).
// Fixed latency: product and one-cycle stop appear WIDTH+2 cycles after start is presented.
module booth_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic          Clock,
  input  logic          Reset,
  booth_mult_param_if.slave mult
);

  // Operands are widened by one bit so the most-negative signed value and the
  // all-ones unsigned value both multiply exactly with the same signed Booth core.
  localparam int XW = WIDTH + 1;
  localparam int PW = 2 * WIDTH + 3;

  state_e           state, state_nxt;
  logic [PW-1:0]    a_q, s_q, p_q, p_step;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [XW-1:0]    m_ext, b_ext;
  logic             last_step;

  assign m_ext     = {mult.w_Signed & mult.w_A[WIDTH-1], mult.w_A};
  assign b_ext     = {mult.w_Signed & mult.w_B[WIDTH-1], mult.w_B};
  assign last_step = (cnt_q == CNT_W'(1));

  booth_radix2_step #(.PW(PW)) u_step (
    .p      (p_q),
    .a      (a_q),
    .s      (s_q),
    .p_next (p_step)
  );

  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mult.w_MultStart) state_nxt = RUN;
      RUN:     if (last_step)        state_nxt = DONE;
      DONE:                          state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      a_q   <= '0;
      s_q   <= '0;
      p_q   <= '0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult.w_MultStart) begin
            a_q   <= {m_ext, {(WIDTH + 2){1'b0}}};
            s_q   <= {-m_ext, {(WIDTH + 2){1'b0}}};
            p_q   <= {{XW{1'b0}}, b_ext, 1'b0};
            cnt_q <= CNT_W'(WIDTH + 1);
          end
        end
        RUN: begin
          p_q   <= p_step;
          cnt_q <= cnt_q - CNT_W'(1);
          // Only the final step publishes, so HI/LO never show a partial product.
          if (last_step) begin
            hi_q <= p_step[2*WIDTH:WIDTH+1];
            lo_q <= p_step[WIDTH:1];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mult.w_MultBusy = (state != IDLE);
  assign mult.w_MultStop = (state == DONE);
  assign mult.w_MULTHI   = hi_q;
  assign mult.w_MULTLO   = lo_q;

endmodule
